// File: rtl/ex_div_if.sv
// ex_div_if: EX-stage divider request/response bundle.
//   master : EX stage side; drives start/func3/op1/op2/flush, sees busy/stall/done/result.
//   slave  : divider side; the reverse directions.
interface ex_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       func3;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, func3, op1, op2, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, func3, op1, op2, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative RV32M DIV/DIVU/REM/REMU unit (radix-2 restoring, one bit per cycle).
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ex_div_if.slave
//          start/func3/op1/op2 request, flush abort, busy/stall/done/result response.
// Divide-by-zero and signed overflow complete in one cycle; other ops take WIDTH CALC cycles.
module ex_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    ex_div_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_rem_sel, w_rem_sel_nxt;  // latched func3[1]: 1 = remainder
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic [WIDTH-1:0] r_quot, w_quot_nxt;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_div, w_div_nxt;
    logic [CntW-1:0]  r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_busy, r_done;

    // Operand preprocessing for the launch cycle.
    logic             w_signed;
    logic [WIDTH-1:0] w_mag1, w_mag2;
    assign w_signed = ~bus.func3[0];
    assign w_mag1   = (w_signed && bus.op1[WIDTH-1]) ? ('0 - bus.op1) : bus.op1;
    assign w_mag2   = (w_signed && bus.op2[WIDTH-1]) ? ('0 - bus.op2) : bus.op2;

    // One restoring step: shift, trial subtract, keep on no borrow.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_step_rem, w_step_quot, w_fin_quot, w_fin_rem;
    assign w_shift           = {r_rem, r_quot[WIDTH-1]};
    assign {w_borrow, w_diff} = {1'b0, w_shift} - {2'b00, r_div};
    assign w_step_rem        = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_step_quot       = {r_quot[WIDTH-2:0], ~w_borrow};
    assign w_fin_quot        = r_neg_q ? ('0 - w_step_quot) : w_step_quot;
    assign w_fin_rem         = r_neg_r ? ('0 - w_step_rem) : w_step_rem;

    // func3[2] is always set for M-extension divides; the kept remainder always fits WIDTH bits.
    logic w_unused;
    assign w_unused = ^{bus.func3[2], w_diff[WIDTH]};

    always_comb begin
        w_state_nxt   = r_state;
        w_rem_sel_nxt = r_rem_sel;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_quot_nxt    = r_quot;
        w_rem_nxt     = r_rem;
        w_div_nxt     = r_div;
        w_cnt_nxt     = r_cnt;
        w_result_nxt  = r_result;

        unique case (r_state)
            StIdle: begin
                if (bus.start && !bus.flush) begin
                    w_rem_sel_nxt = bus.func3[1];
                    w_neg_q_nxt   = w_signed & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
                    w_neg_r_nxt   = w_signed & bus.op1[WIDTH-1];
                    w_quot_nxt    = w_mag1;
                    w_div_nxt     = w_mag2;
                    w_rem_nxt     = '0;
                    w_cnt_nxt     = '0;
                    if (bus.op2 == '0) begin
                        w_state_nxt  = StDone;
                        w_result_nxt = bus.func3[1] ? bus.op1 : '1;
                    end else if (w_signed && bus.op1 == MinNeg && bus.op2 == '1) begin
                        w_state_nxt  = StDone;
                        w_result_nxt = bus.func3[1] ? '0 : MinNeg;
                    end else begin
                        w_state_nxt = StCalc;
                    end
                end
            end
            StCalc: begin
                w_rem_nxt  = w_step_rem;
                w_quot_nxt = w_step_quot;
                w_cnt_nxt  = r_cnt + CntW'(1);
                if (r_cnt == CntW'(WIDTH - 1)) begin
                    w_cnt_nxt    = '0;
                    w_result_nxt = r_rem_sel ? w_fin_rem : w_fin_quot;
                    w_state_nxt  = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Flush wins over everything, including a result landing on the same edge.
        if (bus.flush) begin
            w_state_nxt  = StIdle;
            w_cnt_nxt    = '0;
            w_result_nxt = r_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem_sel <= w_rem_sel_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_quot    <= w_quot_nxt;
            r_rem     <= w_rem_nxt;
            r_div     <= w_div_nxt;
            r_cnt     <= w_cnt_nxt;
            r_result  <= w_result_nxt;
            r_busy    <= (w_state_nxt != StIdle);
            r_done    <= (w_state_nxt == StDone);
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.stall  = (bus.start && (r_state == StIdle) && !bus.flush) || (r_state == StCalc);
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: randomized + directed self-checking bench for ex_div_unit against an
// arithmetic reference model of RV32M division semantics.
module tb_ex_div_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] last_exp;

    ex_div_if #(.WIDTH(32)) bus ();

    ex_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M reference: truncating signed division, defined zero/overflow results.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Full transaction: launch, wait for done, check latency/result/stall span, then idle.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
        int cyc;
        int stalls;
        logic [31:0] exp;
        exp = ref_div(f3, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = f3;
        bus.op1   = a;
        bus.op2   = b;
        #1;
        stalls = bus.stall ? 1 : 0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 100) begin
            if (bus.stall) stalls++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(ref_lat(f3, a, b)));
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_stalls"}, 32'(stalls), 32'(ref_lat(f3, a, b) == 1 ? 1 : 33));
        check({tag, "_stall_at_done"}, 32'(bus.stall), 32'd0);
        last_exp = exp;
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_after"}, 32'(bus.done), 32'd0);
    endtask

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = f3;
        bus.op1   = a;
        bus.op2   = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int dones;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check(tag, 32'(dones), 32'd0);
    endtask

    initial begin
        int d_cyc[$];
        logic [31:0] d_res[$];
        logic [2:0] rf3;
        logic [31:0] ra, rb;

        n_cmp = 0;
        n_err = 0;
        last_exp = 32'd0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.func3 = 3'b100;
        bus.op1 = '0;
        bus.op2 = '0;
        bus.flush = 1'b0;
        #23;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        do_op("div_m20_3", 3'b100, 32'hFFFF_FFEC, 32'd3);
        do_op("rem_m20_3", 3'b110, 32'hFFFF_FFEC, 32'd3);
        do_op("remu_m20_3", 3'b111, 32'hFFFF_FFEC, 32'd3);
        do_op("div_z", 3'b100, 32'h1234_5678, 32'd0);
        do_op("divu_z", 3'b101, 32'h1234_5678, 32'd0);
        do_op("rem_z", 3'b110, 32'h1234_5678, 32'd0);
        do_op("remu_z", 3'b111, 32'h1234_5678, 32'd0);
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_min", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_min_2", 3'b100, 32'h8000_0000, 32'd2);

        // Flush mid-CALC: no done, result keeps the last value.
        launch(3'b101, 32'd1000, 32'd10);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_result", bus.result, last_exp);
        expect_quiet("flush_no_done", 40);
        check("flush_result_kept", bus.result, last_exp);
        do_op("divu_9_2", 3'b101, 32'd9, 32'd2);

        // Flush together with start in IDLE: start ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.func3 = 3'b101;
        bus.op1 = 32'd50;
        bus.op2 = 32'd5;
        #1;
        check("flush_start_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'd0);
        expect_quiet("flush_start_no_done", 40);

        // Back-to-back with start held high across DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = 3'b111;
        bus.op1 = 32'd17;
        bus.op2 = 32'd5;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                d_cyc.push_back(cyc);
                d_res.push_back(bus.result);
            end
            if (cyc == 33) bus.func3 = 3'b101;
            if (cyc == 35) bus.start = 1'b0;
        end
        check("b2b_count", 32'(d_cyc.size()), 32'd2);
        if (d_cyc.size() >= 2) begin
            check("b2b_cyc0", 32'(d_cyc[0]), 32'd33);
            check("b2b_res0", d_res[0], 32'd2);
            check("b2b_cyc1", 32'(d_cyc[1]), 32'd67);
            check("b2b_res1", d_res[1], 32'd3);
        end

        // Randomized ops, biased towards interesting operands.
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'(4 + $urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'(($urandom & 32'hF) + 1);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op("rand", rf3, ra, rb);
        end

        // Async reset mid-CALC.
        launch(3'b101, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("mid_rst_no_done", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative RV32M divide/remainder unit in the EX stage. It consumes the operands and funct3 launched by the ID/EX register.
- It drives a stall back toward the IF/ID and ID/EX registers while a division is in flight, then returns a 32-bit result to the EX result mux.
- Algorithm: radix-2 restoring division. One quotient bit per cycle. Divide-by-zero and signed overflow are resolved in a single cycle.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  EX holds a DIV/DIVU/REM/REMU; sampled only in IDLE.
- func3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; latched with start.
- op1  input  WIDTH  dividend (rs1), latched with start.
- op2  input  WIDTH  divisor (rs2), latched with start.
- flush  input  1  branch/jump flush; aborts the operation in flight.
- busy  output  1  registered; high in CALC and DONE.
- stall  output  1  combinational: (start & state==IDLE & ~flush) | (state==CALC).
- done  output  1  registered one-cycle pulse; result valid this cycle.
- result  output  WIDTH  quotient or remainder; held until the next done.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - busy=0, done=0, result=0.
  - Internal quotient, remainder, counter, sign flags and func3 latch all cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1 and flush=0: latch func3.
  - Record sign flags, signed ops only: neg_q = op1[31]^op2[31]; neg_r = op1[31].
  - Load magnitudes: |op1| and |op2| for signed ops, raw values for unsigned ops.
  - Fast paths go straight to DONE with result set on that same edge:
    - op2==0: quotient = all ones; remainder = op1.
    - Signed, op1==0x80000000 and op2==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Otherwise: enter CALC with counter=0 and partial remainder=0.
- CALC, once per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial subtract the divisor from rem. If there is no borrow, keep the difference and shift in quotient bit 1; else shift in 0.
  - counter increments. On the edge where counter==WIDTH-1 completes, compute the final value:
    - Quotient is negated if neg_q (DIV).
    - Remainder is negated if neg_r (REM).
    - func3[1] selects remainder (1) or quotient (0).
    - result is registered and the state moves to DONE.
- DONE:
  - done=1 for exactly one cycle; stall=0 so the pipeline advances and captures result.
  - Next edge returns to IDLE with done=0.
- Latency:
  - Normal ops: start edge E0, done high after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - Fast paths: done high after edge E1.
- start while in CALC or DONE: ignored; no re-latch.
- start in IDLE in the same cycle that DONE→IDLE just occurred: accepted normally, giving back-to-back divisions.
- flush:
  - Any state: next edge forces IDLE with done=0. result keeps its prior value and the counter clears.
  - flush together with start in IDLE: the start is ignored.
- Reset asserted mid-CALC: immediate abort to the reset values; no done is produced.
- Arithmetic: all subtraction in WIDTH+1 bits for borrow detection. Magnitude of 0x80000000 is 0x80000000 treated as unsigned.

Test Plan:
- DIVU op1=100, op2=7, start 1 cycle -> stall high 33 cycles; done pulse once; result=14; busy low the cycle after done.
- DIV op1=-20 (0xFFFFFFEC), op2=3 -> result=0xFFFFFFFA (-6). REM with same operands -> result=0xFFFFFFFE (-2). REMU 0xFFFFFFEC % 3 -> result=2.
- DIV/DIVU op2=0, op1=0x12345678 -> done 1 cycle after start; quotient 0xFFFFFFFF. REM/REMU same operands -> 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF -> fast path, result=0x80000000. REM same operands -> 0.
- DIVU 1000/10 started, flush asserted at cycle 10 of CALC -> IDLE next edge; no done; result unchanged. New DIVU 9/2 -> result=4 after 33 cycles.
- Back-to-back: REMU 17%5 then start held for DIVU 17/5 -> done pulses at cycles 33 and 67; results 2 then 3. rst pulsed mid-CALC -> busy=done=result=0 immediately.
